// File: rtl/up_down_counter_pkg.sv
// Shared types for the dual-channel up/down counter.
// Channel width and direction encoding live here.
package up_down_counter_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/updn_cnt_core.sv
// Next-state logic for one counter channel with range 0..limit.
// Counting up past limit wraps to 0; counting down past 0 reloads limit.
module updn_cnt_core
    import up_down_counter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  dir_e         dir_i,
    input  logic [W-1:0] limit_i,
    input  logic [W-1:0] cnt_i,
    output logic [W-1:0] cnt_d_o
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // >= rather than == so a limit lowered below the count still wraps
    always_comb begin
        cnt_d_o = cnt_i;
        if (dir_i == DIR_UP) begin
            cnt_d_o = (cnt_i >= limit_i) ? '0 : cnt_i + ONE;
        end else begin
            cnt_d_o = (cnt_i == '0) ? limit_i : cnt_i - ONE;
        end
    end

endmodule

// File: rtl/up_down_counter.sv
// Dual 4-bit counter: outu is modulo-16 up/down, outd runs over 0..data.
// Both channels share the same core; state registers live here.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             up_down,
    input  logic             down_up,
    output logic [WIDTH-1:0] outu,
    output logic [WIDTH-1:0] outd
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] outu_q, outu_d;
    logic [WIDTH-1:0] outd_q, outd_d;

    updn_cnt_core #(.W(WIDTH)) u_core_u (
        .dir_i   (dir_e'(up_down)),
        .limit_i (MAX),
        .cnt_i   (outu_q),
        .cnt_d_o (outu_d)
    );

    // down_up=1 means count down, the opposite sense of the core's dir
    updn_cnt_core #(.W(WIDTH)) u_core_d (
        .dir_i   (dir_e'(~down_up)),
        .limit_i (data),
        .cnt_i   (outd_q),
        .cnt_d_o (outd_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outu_q <= '0;
            outd_q <= '0;
        end else begin
            outu_q <= outu_d;
            outd_q <= outd_d;
        end
    end

    assign outu = outu_q;
    assign outd = outd_q;

    a_no_x_inputs : assert property (
        @(posedge clk) disable iff (reset)
        !$isunknown({data, up_down, down_up})
    );

endmodule

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter.
// Expected counts are computed by hand or by simple modular formulas.
module tb_up_down_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] data = 4'd0;
    logic       up_down = 1'b1;
    logic       down_up = 1'b1;
    logic [3:0] outu;
    logic [3:0] outd;

    int n_chk = 0;
    int n_fail = 0;

    up_down_counter dut (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .up_down (up_down),
        .down_up (down_up),
        .outu    (outu),
        .outd    (outd)
    );

    always #2 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; outputs must clear without a clock edge
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("rst_outu", outu, 4'd0);
        chk("rst_outd", outd, 4'd0);
        reset = 1'b0;
    endtask

    initial begin
        up_down = 1'b1;
        down_up = 1'b1;
        data    = 4'd2;
        #1 reset = 1'b1;
        #1;
        chk("init_outu", outu, 4'd0);
        chk("init_outd", outd, 4'd0);
        #1 reset = 1'b0;

        // up count wraps 15->0->1; outd cycles 2,1,0 with data=2
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("t1_outu_%0d", k), outu, 4'(k % 16));
            chk($sformatf("t1_outd_%0d", k), outd, 4'((3 - k % 3) % 3));
        end

        // mid-count reset, then down count and outd up over 0..5
        pulse_reset();
        up_down = 1'b0;
        down_up = 1'b0;
        data    = 4'd5;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("t3_outu_%0d", k), outu, 4'((16 - k) % 16));
            chk($sformatf("t3_outd_%0d", k), outd, 4'(k % 6));
        end

        // reach outd=7 with data=9, then lower data to 3
        step();
        pulse_reset();
        data = 4'd9;
        for (int k = 1; k <= 7; k++) step();
        chk("t4_outd_7", outd, 4'd7);
        data = 4'd3;
        step(); chk("t4_drop", outd, 4'd0);
        step(); chk("t4_a", outd, 4'd1);
        step(); chk("t4_b", outd, 4'd2);
        step(); chk("t4_c", outd, 4'd3);
        step(); chk("t4_wrap", outd, 4'd0);

        // data=0 pins outd; toggle up_down around outu=4
        pulse_reset();
        data    = 4'd0;
        up_down = 1'b1;
        down_up = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("t6_ramp_%0d", k), outu, 4'(k));
            chk($sformatf("t6_d0_%0d", k), outd, 4'd0);
        end
        for (int k = 0; k < 6; k++) begin
            up_down = (k % 2 == 0);
            down_up = (k % 2 == 1);
            step();
            chk($sformatf("t6_tog_%0d", k), outu,
                (k % 2 == 0) ? 4'd5 : 4'd4);
            chk($sformatf("t6_dz_%0d", k), outd, 4'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
